// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Pipeline sequencer for the 5-stage core around the EX/MEM register.
//   Freezes the pipe during multi-cycle data-memory accesses (with a timeout
//   abort), redirects/flushes on taken branch or jump, and inserts a one-cycle
//   bubble on a load-use hazard.
//   Optional feature: define STALL_CNT_EN to build the saturating
//   stall_cycles counter; otherwise stall_cycles is tied to 0.
module mem_stage_ctrl #(
    parameter int MEM_TIMEOUT = 16,  // >= 2
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             Branch_MEM,
    input  logic             Zero_MEM,
    input  logic             Jump_MEM,
    input  logic             mem_ack,
    input  logic             MemRead_EX,
    input  logic [4:0]       Write_register_EX,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    output logic             mem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             pc_src_sel,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;

    localparam int             WCW     = $clog2(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WC_LAST = WCW'(MEM_TIMEOUT - 1);

    logic [1:0]     r_state;
    logic [WCW-1:0] r_wait_cnt;
    logic           r_mem_err;

    logic [1:0]     w_state_nxt;
    logic [WCW-1:0] w_wait_nxt;
    logic           w_timeout;
    logic           w_advance;  // pipe is allowed to move this cycle
    logic           w_acc;
    logic           w_redir;
    logic           w_lu;

    assign w_acc   = MemRead_MEM | MemWrite_MEM;
    assign w_redir = (Branch_MEM & Zero_MEM) | Jump_MEM;
    assign w_lu    = MemRead_EX && (Write_register_EX != 5'd0) &&
                     ((Write_register_EX == Rs_ID) || (Write_register_EX == Rt_ID));

    // Next-state logic and combinational stage controls from state + inputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait_cnt;
        w_timeout    = 1'b0;
        w_advance    = 1'b0;
        mem_req      = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        pc_src_sel   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        case (r_state)
            S_RUN: begin
                mem_req = w_acc;
                if (w_acc && !mem_ack) begin
                    // Multi-cycle access starts: freeze now, count this cycle as 1.
                    w_state_nxt = S_MEM_WAIT;
                    w_wait_nxt  = WCW'(1);
                end else begin
                    w_advance = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    // Release the freeze in the ack cycle; a pending redirect issues now.
                    w_advance   = 1'b1;
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == WC_LAST) begin
                    // Abort: kill the stuck access and go drain the front end.
                    w_timeout    = 1'b1;
                    ex_mem_flush = 1'b1;
                    w_state_nxt  = S_DRAIN;
                    w_wait_nxt   = '0;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                // One cycle of bubbles behind the aborted access; PC holds.
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                w_state_nxt  = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_wait_nxt  = '0;
            end
        endcase

        if (w_advance) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (w_redir) begin
                // Redirect wins; the load-use instruction is flushed anyway.
                pc_src_sel   = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (w_lu) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        // Outputs are held inactive while reset is asserted.
        if (!rst_n) begin
            mem_req      = 1'b0;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_en    = 1'b0;
            pc_src_sel   = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
        end
    end

    // State, wait counter and registered timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops sample pre-edge values together.
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= w_timeout;
        end
    end

    assign mem_err = r_mem_err;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
//   Directed scenarios plus a randomized run, all compared cycle by cycle
//   against a behavioural model of the sequencer kept in this file.
module tb_mem_stage_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;
    localparam int OW          = 11 + CNT_W;

    logic clk = 1'b0;
    logic rst_n;
    logic MemRead_MEM, MemWrite_MEM, Branch_MEM, Zero_MEM, Jump_MEM, mem_ack;
    logic MemRead_EX;
    logic [4:0] Write_register_EX, Rs_ID, Rt_ID;
    logic mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_src_sel;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    mem_stage_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .Branch_MEM(Branch_MEM), .Zero_MEM(Zero_MEM), .Jump_MEM(Jump_MEM),
        .mem_ack(mem_ack), .MemRead_EX(MemRead_EX),
        .Write_register_EX(Write_register_EX), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .mem_req(mem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .pc_src_sel(pc_src_sel),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    logic [OW-1:0] w_obs;
    assign w_obs = {mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_src_sel,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_err, stall_cycles};

    // ---------------- behavioural model ----------------
    bit     m_busy;     // a multi-cycle access is outstanding
    int     m_waited;   // cycles spent on the outstanding access so far
    bit     m_drain;    // abort clean-up cycle is due
    bit     m_err;
    longint m_stall;

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_drain = 0; m_err = 0; m_stall = 0;
    endtask

    // Returns {timeout, mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //          pc_src_sel, if_id_flush, id_ex_flush, ex_mem_flush}.
    function automatic logic [10:0] model_comb();
        bit acc, redir, lu, moves;
        bit tmo, mreq, pc, ifid, idex, exmem, memwb, psel, fifid, fidex, fexmem;
        acc   = MemRead_MEM | MemWrite_MEM;
        redir = (Branch_MEM && Zero_MEM) || Jump_MEM;
        lu    = MemRead_EX && Write_register_EX != 0 &&
                (Write_register_EX == Rs_ID || Write_register_EX == Rt_ID);
        {tmo, mreq, pc, ifid, idex, exmem, memwb, psel, fifid, fidex, fexmem} = '0;
        moves = 0;
        if (m_drain) begin
            {ifid, idex, exmem, memwb} = 4'hF;
            {fifid, fidex, fexmem}     = 3'h7;
        end else if (m_busy) begin
            mreq = 1;
            if (mem_ack) moves = 1;
            else if (m_waited == MEM_TIMEOUT - 1) begin tmo = 1; fexmem = 1; end
        end else begin
            mreq  = acc;
            moves = !(acc && !mem_ack);
        end
        if (moves) begin
            {pc, ifid, idex, exmem, memwb} = 5'h1F;
            if (redir) begin
                psel = 1; {fifid, fidex, fexmem} = 3'h7;
            end else if (lu) begin
                pc = 0; ifid = 0; fidex = 1;
            end
        end
        return {tmo, mreq, pc, ifid, idex, exmem, memwb, psel, fifid, fidex, fexmem};
    endfunction

    function automatic logic [OW-1:0] model_exp();
        logic [10:0]      c;
        logic [CNT_W-1:0] s;
        c = model_comb();
`ifdef STALL_CNT_EN
        s = CNT_W'(m_stall);
`else
        s = '0;
`endif
        return {c[9:0], m_err, s};
    endfunction

    task automatic model_step();
        logic [10:0] c;
        bit acc;
        c   = model_comb();
        acc = MemRead_MEM | MemWrite_MEM;
        if (!c[8] && m_stall < (longint'(1) << CNT_W) - 1) m_stall++;
        m_err = c[10];
        if (m_drain) m_drain = 0;
        else if (m_busy) begin
            if (mem_ack) m_busy = 0;
            else if (c[10]) begin m_busy = 0; m_drain = 1; end
            else m_waited++;
        end else if (acc && !mem_ack) begin
            m_busy = 1; m_waited = 1;
        end
    endtask

    // Advance one clock; leaves time at posedge + 1.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic clear_inputs();
        {MemRead_MEM, MemWrite_MEM, Branch_MEM, Zero_MEM, Jump_MEM, mem_ack, MemRead_EX} = '0;
        Write_register_EX = '0; Rs_ID = '0; Rt_ID = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (w_obs !== '0) $display("FAIL reset_hold got=%h exp=%h", w_obs, {OW{1'b0}});
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== model_exp()) $display("FAIL reset_release got=%h exp=%h", w_obs, model_exp());
        else n_pass++;
        tick();
    endtask

    task automatic test_load_late_ack();
        clear_inputs();
        MemRead_MEM = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            n_checks++;
            if (w_obs !== model_exp()) $display("FAIL t1_model c%0d got=%h exp=%h", i, w_obs, model_exp());
            else n_pass++;
            n_checks++;
            if ({pc_en, mem_req} !== ((i < 3) ? 2'b01 : 2'b11))
                $display("FAIL t1_pc_req c%0d got=%b exp=%b", i, {pc_en, mem_req}, (i < 3) ? 2'b01 : 2'b11);
            else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_store_zero_wait();
        clear_inputs();
        MemWrite_MEM = 1; mem_ack = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (w_obs !== model_exp() || pc_en !== 1'b1)
                $display("FAIL t2_store c%0d got=%h exp=%h", i, w_obs, model_exp());
            else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        clear_inputs();
        Branch_MEM = 1; Zero_MEM = 1;
        #1;
        n_checks++;
        if (w_obs !== model_exp() || {pc_src_sel, if_id_flush, id_ex_flush, ex_mem_flush} !== 4'hF)
            $display("FAIL t3_taken got=%h exp=%h", w_obs, model_exp());
        else n_pass++;
        tick();
        Zero_MEM = 0;
        #1;
        n_checks++;
        if (w_obs !== model_exp() || {pc_src_sel, if_id_flush, id_ex_flush, ex_mem_flush} !== 4'h0)
            $display("FAIL t3_not_taken got=%h exp=%h", w_obs, model_exp());
        else n_pass++;
        tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        MemRead_EX = 1; Write_register_EX = 5; Rt_ID = 5; Rs_ID = 2;
        #1;
        n_checks++;
        if (w_obs !== model_exp() || {pc_en, if_id_en, id_ex_flush} !== 3'b001)
            $display("FAIL t4_bubble got=%h exp=%h", w_obs, model_exp());
        else n_pass++;
        tick();
        Write_register_EX = 0; Rt_ID = 0;
        #1;
        n_checks++;
        if (w_obs !== model_exp() || {pc_en, if_id_en, id_ex_flush} !== 3'b110)
            $display("FAIL t4_r0 got=%h exp=%h", w_obs, model_exp());
        else n_pass++;
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        clear_inputs();
        MemRead_MEM = 1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            #1;
            n_checks++;
            if (w_obs !== model_exp() || mem_err !== 1'b0 || pc_en !== 1'b0 ||
                ex_mem_flush !== (i == MEM_TIMEOUT - 1))
                $display("FAIL t5_wait c%0d got=%h exp=%h", i, w_obs, model_exp());
            else n_pass++;
            tick();
        end
        MemRead_MEM = 0;
        #1;
        n_checks++;
        if (w_obs !== model_exp() || {mem_err, mem_req, pc_en, if_id_flush, id_ex_flush, ex_mem_flush} !== 6'b100111)
            $display("FAIL t5_drain got=%h exp=%h", w_obs, model_exp());
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (w_obs !== model_exp() || {mem_err, pc_en} !== 2'b01)
            $display("FAIL t5_run got=%h exp=%h", w_obs, model_exp());
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        MemRead_MEM = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (w_obs !== model_exp()) $display("FAIL t6_wait c%0d got=%h exp=%h", i, w_obs, model_exp());
            else n_pass++;
            tick();
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (w_obs !== '0) $display("FAIL t6_async got=%h exp=%h", w_obs, {OW{1'b0}});
        else n_pass++;
        MemRead_MEM = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== model_exp() || {pc_en, mem_req, mem_err} !== 3'b100)
            $display("FAIL t6_after got=%h exp=%h", w_obs, model_exp());
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            MemRead_MEM       = ($urandom_range(0, 9) < 2);
            MemWrite_MEM      = ($urandom_range(0, 9) < 1);
            Branch_MEM        = ($urandom_range(0, 9) < 3);
            Zero_MEM          = $urandom_range(0, 1);
            Jump_MEM          = ($urandom_range(0, 9) < 1);
            mem_ack           = ($urandom_range(0, 9) < 4);
            MemRead_EX        = $urandom_range(0, 1);
            Write_register_EX = 5'($urandom_range(0, 3));
            Rs_ID             = 5'($urandom_range(0, 3));
            Rt_ID             = 5'($urandom_range(0, 3));
            #1;
            n_checks++;
            if (w_obs !== model_exp()) $display("FAIL rand c%0d got=%h exp=%h", i, w_obs, model_exp());
            else n_pass++;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_late_ack();
        test_store_zero_wait();
        test_branch();
        test_load_use();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
